// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and popcount helper for the register file
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ZERO     = 0;
    localparam int POP_MAX      = 1024;

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write busy bits with flush/clear/set priority and count
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG),
    localparam int CW   = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic            issue,
    input  logic [AW-1:0]   issue_addr,
    output logic [NREG-1:0] busy,
    output logic [CW-1:0]   busy_cnt
);

    logic [NREG-1:0]    bits_next;
    logic [POP_MAX-1:0] pad;

    // Set is applied after clear so a fresh producer supersedes the retiring one.
    always_comb begin
        bits_next = busy;
        if (flush) begin
            bits_next = '0;
        end else begin
            if (wr_en && wr_addr != AW'(REG_ZERO))
                bits_next[wr_addr] = 1'b0;
            if (issue && issue_addr != AW'(REG_ZERO))
                bits_next[issue_addr] = 1'b1;
        end
    end

    always_comb begin
        pad = '0;
        pad[NREG-1:0] = bits_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= bits_next;
            busy_cnt <= CW'(popcount(pad));
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with write bypass and pending-write scoreboard
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int NREG   = 32,
    parameter  int NRD    = 2,
    parameter  bit BYPASS = 1'b1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [XLEN-1:0]     IN,
    input  logic [AW-1:0]       INADDRESS,
    input  logic                WRITE,
    input  logic [NRD*AW-1:0]   OUTADDRESS,
    output logic [NRD*XLEN-1:0] OUT,
    input  logic                ISSUE,
    input  logic [AW-1:0]       ISSUE_ADDR,
    input  logic                FLUSH,
    output logic [NRD-1:0]      PENDING,
    output logic                HAZARD,
    output logic [AW:0]         BUSY_CNT
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [AW-1:0]   raddr;
    logic            wr_hit;

    // Gated by reset so a write held during reset neither lands nor bypasses.
    assign wr_hit = RESET && WRITE && (INADDRESS != AW'(REG_ZERO));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_hit) begin
            regs[INADDRESS] <= IN;
        end
    end

    regfile_scoreboard #(.NREG(NREG)) u_sb (
        .clk        (CLK),
        .rst_n      (RESET),
        .flush      (FLUSH),
        .wr_en      (wr_hit),
        .wr_addr    (INADDRESS),
        .issue      (ISSUE),
        .issue_addr (ISSUE_ADDR),
        .busy       (busy),
        .busy_cnt   (BUSY_CNT)
    );

    always_comb begin
        OUT     = '0;
        PENDING = '0;
        raddr   = '0;
        for (int k = 0; k < NRD; k++) begin
            raddr = OUTADDRESS[k*AW +: AW];
            assert (int'(raddr) < NREG);
            if (raddr == AW'(REG_ZERO) || int'(raddr) >= NREG) begin
                OUT[k*XLEN +: XLEN] = '0;
            end else if (BYPASS && wr_hit && INADDRESS == raddr) begin
                OUT[k*XLEN +: XLEN] = IN;
            end else begin
                OUT[k*XLEN +: XLEN] = regs[raddr];
            end
            // A value forwarded this cycle no longer blocks its consumer.
            PENDING[k] = busy[raddr] && !(BYPASS && wr_hit && INADDRESS == raddr);
        end
    end

    assign HAZARD = |PENDING;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed vector bench for reg_file_sb
module tb_reg_file_sb;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IN;
    logic [4:0]  INADDRESS;
    logic        WRITE;
    logic [9:0]  OUTADDRESS;
    logic        ISSUE;
    logic [4:0]  ISSUE_ADDR;
    logic        FLUSH;

    logic [63:0] out_b, out_n;
    logic [1:0]  pend_b, pend_n;
    logic        haz_b, haz_n;
    logic [5:0]  cnt_b, cnt_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    reg_file_sb #(.BYPASS(1'b1)) u_byp (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .OUTADDRESS(OUTADDRESS), .OUT(out_b), .ISSUE(ISSUE), .ISSUE_ADDR(ISSUE_ADDR),
        .FLUSH(FLUSH), .PENDING(pend_b), .HAZARD(haz_b), .BUSY_CNT(cnt_b)
    );

    reg_file_sb #(.BYPASS(1'b0)) u_nob (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .OUTADDRESS(OUTADDRESS), .OUT(out_n), .ISSUE(ISSUE), .ISSUE_ADDR(ISSUE_ADDR),
        .FLUSH(FLUSH), .PENDING(pend_n), .HAZARD(haz_n), .BUSY_CNT(cnt_n)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  ep;
        logic        eh;
        logic [5:0]  ec;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                         input logic iss, input logic [4:0] ia, input logic fl,
                         input logic [4:0] r0, input logic [4:0] r1);
        WRITE = wr; INADDRESS = wa; IN = wd;
        ISSUE = iss; ISSUE_ADDR = ia; FLUSH = fl;
        OUTADDRESS = {r1, r0};
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // columns: wr wa wd iss ia fl r0 r1 | out0 out1 pend haz cnt (values seen before the edge)
        vq.push_back('{1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,5'd0,5'd0,  32'h0,       32'h0,       2'b00,1'b0,6'd0});
        vq.push_back('{1'b1,5'd7, 32'h12345678,1'b0,5'd0, 1'b0,5'd7,5'd0,  32'h12345678,32'h0,       2'b00,1'b0,6'd0});
        vq.push_back('{1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,5'd0,5'd7,  32'h0,       32'h12345678,2'b00,1'b0,6'd0});
        vq.push_back('{1'b1,5'd0, 32'hFFFFFFFF,1'b0,5'd0, 1'b0,5'd0,5'd0,  32'h0,       32'h0,       2'b00,1'b0,6'd0});
        vq.push_back('{1'b1,5'd3, 32'hA5A5A5A5,1'b0,5'd0, 1'b0,5'd3,5'd3,  32'hA5A5A5A5,32'hA5A5A5A5,2'b00,1'b0,6'd0});
        vq.push_back('{1'b0,5'd0, 32'h0,       1'b1,5'd9, 1'b0,5'd9,5'd3,  32'h0,       32'hA5A5A5A5,2'b00,1'b0,6'd0});
        vq.push_back('{1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,5'd9,5'd3,  32'h0,       32'hA5A5A5A5,2'b01,1'b1,6'd1});
        vq.push_back('{1'b1,5'd9, 32'h99,      1'b0,5'd0, 1'b0,5'd9,5'd9,  32'h99,      32'h99,      2'b00,1'b0,6'd1});
        vq.push_back('{1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,5'd9,5'd0,  32'h99,      32'h0,       2'b00,1'b0,6'd0});
        vq.push_back('{1'b1,5'd4, 32'h44,      1'b1,5'd4, 1'b0,5'd4,5'd0,  32'h44,      32'h0,       2'b00,1'b0,6'd0});
        vq.push_back('{1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,5'd4,5'd0,  32'h44,      32'h0,       2'b01,1'b1,6'd1});
        vq.push_back('{1'b0,5'd0, 32'h0,       1'b1,5'd0, 1'b0,5'd0,5'd4,  32'h0,       32'h44,      2'b10,1'b1,6'd1});
        vq.push_back('{1'b0,5'd0, 32'h0,       1'b1,5'd10,1'b0,5'd4,5'd10, 32'h44,      32'h0,       2'b01,1'b1,6'd1});
        vq.push_back('{1'b0,5'd0, 32'h0,       1'b1,5'd6, 1'b1,5'd4,5'd6,  32'h44,      32'h0,       2'b01,1'b1,6'd2});
        vq.push_back('{1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,5'd4,5'd6,  32'h44,      32'h0,       2'b00,1'b0,6'd0});
        vq.push_back('{1'b0,5'd0, 32'h0,       1'b1,5'd4, 1'b0,5'd4,5'd4,  32'h44,      32'h44,      2'b00,1'b0,6'd0});
        vq.push_back('{1'b0,5'd0, 32'h0,       1'b1,5'd4, 1'b0,5'd4,5'd4,  32'h44,      32'h44,      2'b11,1'b1,6'd1});
        vq.push_back('{1'b1,5'd5, 32'h55,      1'b0,5'd0, 1'b0,5'd4,5'd5,  32'h44,      32'h55,      2'b01,1'b1,6'd1});
        vq.push_back('{1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,5'd5,5'd4,  32'h55,      32'h44,      2'b10,1'b1,6'd1});

        // Reset asserted from time zero; a write and issue during reset must be ignored.
        RESET = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        #1;
        chk("reset out", out_b, 64'h0);
        chk("reset cnt", {58'h0, cnt_b}, 64'h0);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 5'd5, 5'd5);
        #1;
        chk("reset no bypass", out_b, 64'h0);
        tick();
        chk("reset write dropped", out_b, 64'h0);
        chk("reset issue dropped", {58'h0, cnt_b}, 64'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
        RESET = 1'b1;
        tick();
        chk("x5 after release", out_b, 64'h0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].wr, vq[i].wa, vq[i].wd, vq[i].iss, vq[i].ia, vq[i].fl, vq[i].r0, vq[i].r1);
            #2;
            chk($sformatf("row%0d out0", i), {32'h0, out_b[31:0]},  {32'h0, vq[i].e0});
            chk($sformatf("row%0d out1", i), {32'h0, out_b[63:32]}, {32'h0, vq[i].e1});
            chk($sformatf("row%0d pend", i), {62'h0, pend_b}, {62'h0, vq[i].ep});
            chk($sformatf("row%0d haz", i),  {63'h0, haz_b},  {63'h0, vq[i].eh});
            chk($sformatf("row%0d cnt", i),  {58'h0, cnt_b},  {58'h0, vq[i].ec});
            tick();
        end

        // Pending x3, then written: bypassing instance forwards and clears the hazard, the other does not.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3);
        tick();
        drive(1'b1, 5'd3, 32'h5A5A5A5A, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
        #2;
        chk("byp fwd out", out_b, 64'h5A5A5A5A_5A5A5A5A);
        chk("byp fwd pend", {62'h0, pend_b}, 64'h0);
        chk("nob old out", out_n, 64'hA5A5A5A5_A5A5A5A5);
        chk("nob pend", {62'h0, pend_n}, 64'h3);
        chk("nob haz", {63'h0, haz_n}, 64'h1);
        chk("byp cnt two", {58'h0, cnt_b}, 64'h2);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
        #2;
        chk("nob stored out", out_n, 64'h5A5A5A5A_5A5A5A5A);
        chk("nob pend cleared", {62'h0, pend_n}, 64'h0);
        chk("nob cnt", {58'h0, cnt_n}, 64'h1);
        tick();

        // Build three pending bits, then pull reset mid-cycle.
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd1);
        #1;
        chk("pre-reset cnt", {58'h0, cnt_b}, 64'h3);
        chk("pre-reset out", out_b, 64'h00000000_12345678);
        chk("pre-reset pend", {62'h0, pend_b}, 64'h2);
        #1;
        RESET = 1'b0;
        #1;
        chk("async reset cnt", {58'h0, cnt_b}, 64'h0);
        chk("async reset out", out_b, 64'h0);
        chk("async reset pend", {62'h0, pend_b}, 64'h0);
        chk("async reset haz", {63'h0, haz_b}, 64'h0);
        tick();
        RESET = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd5);
        tick();
        chk("regs cleared", out_b, 64'h0);
        chk("cnt after reset", {58'h0, cnt_b}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
